// File: rtl/bin2bcd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bin2bcd_scan_ctrl                                            |
// | Description : 14-bit binary to 4-digit BCD converter (serial double-dabble)|
// |               feeding a multiplexed 4-digit display scanner with optional  |
// |               leading-zero blanking and registered digit outputs.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bin2bcd_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int LZ_BLANK    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] bin_in,
   input  logic        load,
   output logic        busy,
   output logic        ovf,
   output logic [3:0]  digit_bcd,
   output logic [3:0]  digit_en
);

   localparam int                 c_CNT_W     = $clog2(REFRESH_DIV);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(REFRESH_DIV - 1);
   localparam logic [13:0]        c_BIN_MAX   = 14'd9999;
   localparam logic [3:0]         c_LAST_ITER = 4'd13;

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_CONV = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_next;
   logic               w_capture;
   logic               w_done;
   logic [3:0]         r_iter;
   logic [29:0]        r_shift;
   logic [29:0]        w_adj;
   logic [29:0]        w_shift_next;
   logic [13:0]        w_bin_sat;
   logic [15:0]        r_display;
   logic               r_ovf;
   logic [c_CNT_W-1:0] r_cnt;
   logic [1:0]         r_idx;
   logic [3:0]         w_sel_bcd;
   logic               w_lz;
   logic               w_blank;
   logic [3:0]         r_digit_bcd;
   logic [3:0]         r_digit_en;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: accept a load only when idle, leave CONV after the last iteration
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:  if (load) w_state_next = c_CONV;
         c_CONV:  if (r_iter == c_LAST_ITER) w_state_next = c_IDLE;
         default: w_state_next = c_IDLE;
      endcase
   end

   // FSM outputs: busy flag, capture strobe and completion strobe
   always_comb begin
      busy      = (r_state == c_CONV);
      w_capture = (r_state == c_IDLE) && load;
      w_done    = (r_state == c_CONV) && (r_iter == c_LAST_ITER);
   end

   // Values above the 4-digit range are clamped so the BCD result stays valid
   assign w_bin_sat = (bin_in > c_BIN_MAX) ? c_BIN_MAX : bin_in;

   // Add-3 correction on each BCD nibble of the shift register
   for (genvar g = 0; g < 4; g++) begin : g_dabble
      assign w_adj[14+4*g +: 4] = (r_shift[14+4*g +: 4] >= 4'd5) ?
                                  (r_shift[14+4*g +: 4] + 4'd3) :
                                   r_shift[14+4*g +: 4];
   end
   assign w_adj[13:0] = r_shift[13:0];

   // Rotate instead of plain shift: the bit wrapping to the bottom is always zero
   // for clamped inputs and never climbs into the BCD field within 14 steps.
   assign w_shift_next = {w_adj[28:0], w_adj[29]};

   // Conversion datapath: capture, iterate, and publish the result on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_iter    <= '0;
         r_display <= '0;
         r_ovf     <= 1'b0;
      end else if (w_capture) begin
         r_shift <= {16'h0000, w_bin_sat};
         r_iter  <= '0;
         r_ovf   <= (bin_in > c_BIN_MAX);
      end else if (busy) begin
         r_shift <= w_shift_next;
         r_iter  <= r_iter + 4'd1;
         if (w_done) begin
            r_display <= w_shift_next[29:14];
         end
      end
   end

   assign ovf = r_ovf;

   // Free-running refresh counter and digit index, independent of conversions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Select the current nibble and decide whether it is a leading zero
   always_comb begin
      w_sel_bcd = r_display[{r_idx, 2'b00} +: 4];
      case (r_idx)
         2'd1:    w_lz = (r_display[15:4]  == 12'h000);
         2'd2:    w_lz = (r_display[15:8]  == 8'h00);
         2'd3:    w_lz = (r_display[15:12] == 4'h0);
         default: w_lz = 1'b0;
      endcase
      w_blank = (LZ_BLANK != 0) && w_lz;
   end

   // Registered digit outputs; reset state shows digit 0 lit with value 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit_bcd <= 4'd0;
         r_digit_en  <= 4'b1110;
      end else if (w_blank) begin
         r_digit_bcd <= 4'd0;
         r_digit_en  <= 4'b1111;
      end else begin
         r_digit_bcd <= w_sel_bcd;
         r_digit_en  <= ~(4'b0001 << r_idx);
      end
   end

   assign digit_bcd = r_digit_bcd;
   assign digit_en  = r_digit_en;

endmodule
`default_nettype wire
